// File: rtl/opl3_write_sequencer.sv
`default_nettype none
// opl3_write_sequencer: buffers CPU writes to the OPL3 core in a FIFO and replays them with a fixed idle gap.
// Optional: OPL3_WRSEQ_SAMPLE_SYNC_EN gates issue on a window that opens after each sample_clk rise.
module opl3_write_sequencer #(
   parameter int DEPTH_LOG2  = 4,
   parameter int GAP_CYCLES  = 32,
   parameter int SYNC_WINDOW = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_we,
   input  logic [8:0]  cpu_adr,
   input  logic [7:0]  cpu_data,
   input  logic        status_clr,
   input  logic        sample_clk,
   output logic        opl3_we,
   output logic [8:0]  opl3_adr,
   output logic [7:0]  opl3_data,
   output logic        fifo_full,
   output logic        busy,
   output logic [15:0] status
);
   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [16:0]           mem_q [DEPTH];
   logic                  ovfl_q, ovfl_d;
   logic [8:0]            adr_q, adr_d;
   logic [7:0]            data_q, data_d;
   logic [7:0]            gap_q, gap_d;
   logic                  empty, push, pop, window_open;

`ifdef OPL3_WRSEQ_SAMPLE_SYNC_EN
   localparam int WIN_W = $clog2(SYNC_WINDOW + 1);
   logic             sclk_q, sclk_d, sclk_prev_q, sclk_prev_d;
   logic [WIN_W-1:0] win_q, win_d;

   always_comb begin
      sclk_d      = sample_clk;
      sclk_prev_d = sclk_q;
      win_d       = win_q;
      if (sclk_q && !sclk_prev_q)
         win_d = WIN_W'(SYNC_WINDOW);
      else if (win_q != '0)
         win_d = win_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_q      <= 1'b0;
         sclk_prev_q <= 1'b0;
         win_q       <= '0;
      end else begin
         sclk_q      <= sclk_d;
         sclk_prev_q <= sclk_prev_d;
         win_q       <= win_d;
      end
   end

   assign window_open = (win_q != '0);
`else
   logic unused_sync;
   assign unused_sync = sample_clk ^ (SYNC_WINDOW == 0);
   assign window_open = 1'b1;
`endif

   assign empty     = (level_q == '0);
   assign fifo_full = (level_q == (DEPTH_LOG2 + 1)'(DEPTH));
   assign busy      = !empty || (state_q != ST_IDLE);
   assign opl3_we   = (state_q == ST_ISSUE);
   assign opl3_adr  = adr_q;
   assign opl3_data = data_q;
   assign status    = {ovfl_q, fifo_full, empty, 4'b0, 9'(level_q)};

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovfl_d   = ovfl_q;
      adr_d    = adr_q;
      data_d   = data_q;
      gap_d    = gap_q;
      push     = cpu_we && !fifo_full;
      pop      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!empty && window_open) begin
               pop     = 1'b1;
               adr_d   = mem_q[rd_ptr_q][16:8];
               data_d  = mem_q[rd_ptr_q][7:0];
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (GAP_CYCLES == 0) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_GAP;
               gap_d   = 8'(GAP_CYCLES - 1);
            end
         end
         ST_GAP: begin
            if (gap_q == '0)
               state_d = ST_IDLE;
            else
               gap_d = gap_q - 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)
         level_d = level_q + 1'b1;
      else if (pop && !push)
         level_d = level_q - 1'b1;

      // A dropped write outranks a clear in the same cycle.
      if (cpu_we && fifo_full)
         ovfl_d = 1'b1;
      else if (status_clr)
         ovfl_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovfl_q   <= 1'b0;
         adr_q    <= '0;
         data_q   <= '0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovfl_q   <= ovfl_d;
         adr_q    <= adr_d;
         data_q   <= data_d;
         gap_q    <= gap_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {cpu_adr, cpu_data};
   end
endmodule
`default_nettype wire

// File: tb/tb_opl3_write_sequencer.sv
`default_nettype none
// tb_opl3_write_sequencer: directed tests of the OPL3 write sequencer (GAP_CYCLES=32 and GAP_CYCLES=0 instances).
module tb_opl3_write_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_we = 1'b0;
   logic [8:0]  cpu_adr = '0;
   logic [7:0]  cpu_data = '0;
   logic        status_clr = 1'b0;
   logic        sample_clk = 1'b0;

   logic        opl3_we, fifo_full, busy;
   logic [8:0]  opl3_adr;
   logic [7:0]  opl3_data;
   logic [15:0] status;
   logic        z_opl3_we, z_fifo_full, z_busy;
   logic [8:0]  z_opl3_adr;
   logic [7:0]  z_opl3_data;
   logic [15:0] z_status;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int peak = 0;
   int p_cyc[$];
   int p_adr[$];
   int p_dat[$];
   int z_cyc[$];

   opl3_write_sequencer #(.DEPTH_LOG2(4), .GAP_CYCLES(32), .SYNC_WINDOW(4)) dut (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_data(cpu_data),
      .status_clr(status_clr), .sample_clk(sample_clk), .opl3_we(opl3_we), .opl3_adr(opl3_adr),
      .opl3_data(opl3_data), .fifo_full(fifo_full), .busy(busy), .status(status)
   );

   opl3_write_sequencer #(.DEPTH_LOG2(4), .GAP_CYCLES(0), .SYNC_WINDOW(4)) dut0 (
      .clk(clk), .reset(reset), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_data(cpu_data),
      .status_clr(status_clr), .sample_clk(sample_clk), .opl3_we(z_opl3_we), .opl3_adr(z_opl3_adr),
      .opl3_data(z_opl3_data), .fifo_full(z_fifo_full), .busy(z_busy), .status(z_status)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (opl3_we) begin
         p_cyc.push_back(cyc);
         p_adr.push_back(int'(opl3_adr));
         p_dat.push_back(int'(opl3_data));
      end
      if (z_opl3_we) z_cyc.push_back(cyc);
      if (int'(status[8:0]) > peak) peak = int'(status[8:0]);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [8:0] a, input logic [7:0] d);
      cpu_we   = 1'b1;
      cpu_adr  = a;
      cpu_data = d;
      tick();
      cpu_we   = 1'b0;
   endtask

   task automatic clear_log();
      p_cyc.delete();
      p_adr.delete();
      p_dat.delete();
      z_cyc.delete();
      peak = 0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while ((busy || z_busy) && k < budget) begin
         tick();
         k++;
      end
      check("idle_timeout", {31'b0, busy | z_busy}, 32'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      repeat (3) tick();
      reset = 1'b0;
      check("rst_status", status, 32'h2000);
      check("rst_we", opl3_we, 0);
      check("rst_adr", opl3_adr, 0);
      check("rst_data", opl3_data, 0);
      check("rst_busy", busy, 0);
      check("rst_full", fifo_full, 0);
`ifdef OPL3_WRSEQ_SAMPLE_SYNC_EN
      clear_log();
      wr(9'h001, 8'hA1);
      wr(9'h002, 8'hA2);
      repeat (20) tick();
      check("sync_closed", p_cyc.size(), 0);
      sample_clk = 1'b1; tick(); sample_clk = 1'b0;
      repeat (60) tick();
      check("sync_one", p_cyc.size(), 1);
      sample_clk = 1'b1; tick(); sample_clk = 1'b0;
      repeat (60) tick();
      check("sync_two", p_cyc.size(), 2);
      if (p_dat.size() == 2) begin
         check("sync_d0", p_dat[0], 32'hA1);
         check("sync_d1", p_dat[1], 32'hA2);
      end
`else
      // Single write: pulse two cycles after the strobe, busy drops after the gap.
      clear_log();
      wr(9'h0B0, 8'h31);
      check("single_we_n1", opl3_we, 0);
      check("single_lvl_n1", status, 32'h0001);
      tick();
      check("single_we_n2", opl3_we, 1);
      check("single_adr", opl3_adr, 32'h0B0);
      check("single_data", opl3_data, 32'h31);
      k = 0;
      while (busy && k < 100) begin
         tick();
         k++;
      end
      check("single_busy", busy, 0);
      check("single_busy_cycles", k, 33);
      check("single_hold_adr", opl3_adr, 32'h0B0);
      check("single_hold_data", opl3_data, 32'h31);

      // Burst of five.
      clear_log();
      for (int i = 0; i < 5; i++) wr(9'(9'h0A0 + i), 8'(i + 1));
      wait_idle(300);
      check("burst_count", p_cyc.size(), 5);
      check("burst_peak", peak, 4);
      for (int i = 0; i < p_cyc.size() && i < 5; i++) begin
         check("burst_data", p_dat[i], i + 1);
         check("burst_adr", p_adr[i], 32'h0A0 + i);
         if (i > 0) check("burst_spacing", p_cyc[i] - p_cyc[i-1], 34);
      end

      // Overflow: 18 back-to-back writes, 17 accepted.
      clear_log();
      for (int i = 0; i < 18; i++) wr(9'(i), 8'(i));
      check("ovfl_status", status, 32'hC010);
      check("ovfl_full", fifo_full, 1);
      cpu_we = 1'b1; cpu_data = 8'hEE; status_clr = 1'b1;
      tick();
      cpu_we = 1'b0;
      check("ovfl_set_wins", status[15], 1);
      tick();
      status_clr = 1'b0;
      check("ovfl_cleared", status, 32'h4010);
      wait_idle(800);
      check("ovfl_count", p_cyc.size(), 17);
      for (int i = 0; i < p_dat.size() && i < 17; i++) check("ovfl_order", p_dat[i], i);

      // Push and pop in the same cycle.
      clear_log();
      wr(9'h010, 8'h55);
      check("pp_lvl_a", status, 32'h0001);
      wr(9'h011, 8'h66);
      check("pp_lvl_b", status, 32'h0001);
      check("pp_we", opl3_we, 1);
      check("pp_data", opl3_data, 32'h55);
      wait_idle(200);

      // Zero gap: pulses two cycles apart.
      clear_log();
      for (int i = 0; i < 3; i++) wr(9'h020, 8'(i));
      wait_idle(200);
      check("gap0_count", z_cyc.size(), 3);
      for (int i = 1; i < z_cyc.size() && i < 3; i++) check("gap0_spacing", z_cyc[i] - z_cyc[i-1], 2);

      // Reset mid-burst with eight entries queued.
      for (int i = 0; i < 9; i++) wr(9'h030, 8'(8'h80 + i));
      check("mid_lvl", status, 32'h0008);
      reset = 1'b1;
      tick();
      check("mid_status", status, 32'h2000);
      check("mid_we", opl3_we, 0);
      check("mid_adr", opl3_adr, 0);
      check("mid_data", opl3_data, 0);
      reset = 1'b0;
      clear_log();
      repeat (60) tick();
      check("mid_no_pulses", p_cyc.size(), 0);
      check("mid_busy", busy, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
